// File: rtl/control_mul.sv
// -----------------------------------------------------------------------------
// control_mul -- sequencing controller for a complex multiplier
//
// Purpose:
//   The datapath has one real multiplier, two partial-product registers
//   (pp1, pp2), one add/sub unit and the result registers (p_r, p_i). This
//   controller time-shares the multiplier over four products for each operand
//   pair and computes p = a*b, where p_r = ar*br - ai*bi and p_i = ar*bi + ai*br.
//   It performs no arithmetic itself. Product format is [7:-24].
//
// Optional feature (macro CONTROL_MUL_CONJ_EN):
//   Adds input conj. It is latched on every cycle that issues the PP_RR
//   controls. A latched 1 makes the result a*conj(b).
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   asynchronous, active-high reset
//   in_valid    in   operand pair a,b present, held until accepted
//   in_ready    out  operand acceptance (1 only in PP_IR)
//   out_valid   out  p_r/p_i hold a complete result
//   out_ready   in   consumer takes the result
//   conj        in   (CONTROL_MUL_CONJ_EN only) conjugate b for this op
//   a_sel/b_sel out  operand mux selects (0 = real, 1 = imaginary)
//   pp1_ce      out  load multiplier output into pp1
//   pp2_ce      out  load multiplier output into pp2
//   sub         out  add/sub unit computes pp1-pp2 (1) or pp1+pp2 (0)
//   p_r_ce      out  load add/sub output into p_r
//   p_i_ce      out  load add/sub output into p_i
//   op_count    out  completed results, wraps at 16 bits
//   o_dbg_state out  current FSM state, for observation only
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_valid must stay high with stable operands until in_valid &
// in_ready. out_valid stays high until out_valid & out_ready.
// -----------------------------------------------------------------------------
module control_mul (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
`ifdef CONTROL_MUL_CONJ_EN
  input  logic        conj,
`endif
  output logic        a_sel,
  output logic        b_sel,
  output logic        pp1_ce,
  output logic        pp2_ce,
  output logic        sub,
  output logic        p_r_ce,
  output logic        p_i_ce,
  output logic [15:0] op_count,
  output logic [2:0]  o_dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PP_RR = 3'd1,
    PP_II = 3'd2,
    PR_RI = 3'd3,
    PP_IR = 3'd4,
    PI_WR = 3'd5
  } state_t;

  state_t      r_state;
  logic        r_out_valid;
  logic [15:0] r_op_count;

  logic w_stall;
  logic w_issue_rr;
  logic w_conj;

  // p_r would be overwritten while the consumer still holds the last result,
  // so PR_RI waits. A same-cycle take (out_ready=1) frees p_r in time.
  assign w_stall = (r_state == PR_RI) && r_out_valid && !out_ready;

`ifdef CONTROL_MUL_CONJ_EN
  logic r_conj;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_conj <= 1'b0;
    end else if (w_issue_rr) begin
      r_conj <= conj;
    end
  end

  assign w_conj = r_conj;
`else
  assign w_conj = 1'b0;
`endif

  // Combinational control decode. Gating with rst forces every control low
  // the moment reset asserts, without waiting for a clock edge.
  always_comb begin
    a_sel      = 1'b0;
    b_sel      = 1'b0;
    pp1_ce     = 1'b0;
    pp2_ce     = 1'b0;
    sub        = 1'b0;
    p_r_ce     = 1'b0;
    p_i_ce     = 1'b0;
    in_ready   = 1'b0;
    w_issue_rr = 1'b0;
    if (!rst) begin
      case (r_state)
        PP_RR: begin
          w_issue_rr = 1'b1;
          pp1_ce     = 1'b1;               // ar*br
        end
        PP_II: begin
          a_sel  = 1'b1;
          b_sel  = 1'b1;
          pp2_ce = 1'b1;                   // ai*bi
        end
        PR_RI: begin
          if (!w_stall) begin
            p_r_ce = 1'b1;
            pp1_ce = 1'b1;
            sub    = !w_conj;              // rr-ii, or rr+ii when conjugating
            a_sel  = w_conj;               // conj: ai*br, else ar*bi
            b_sel  = !w_conj;
          end
        end
        PP_IR: begin
          in_ready = 1'b1;                 // last use of a,b for this op
          pp2_ce   = 1'b1;
          a_sel    = !w_conj;              // conj: ar*bi, else ai*br
          b_sel    = w_conj;
        end
        PI_WR: begin
          p_i_ce = 1'b1;
          sub    = w_conj;                 // ri+ir, or ir-ri when conjugating
          // Overlap the next op's first product with this write-back.
          if (in_valid) begin
            w_issue_rr = 1'b1;
            pp1_ce     = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_op_count  <= 16'h0000;
    end else begin
      case (r_state)
        IDLE:    if (in_valid) r_state <= PP_RR;
        PP_RR:   r_state <= PP_II;
        PP_II:   r_state <= PR_RI;
        PR_RI:   if (!w_stall) r_state <= PP_IR;
        PP_IR:   r_state <= PI_WR;
        PI_WR:   r_state <= in_valid ? PP_II : IDLE;
        default: r_state <= IDLE;
      endcase
      // Completing an op wins over the consumer clearing the previous one.
      if (r_state == PI_WR) begin
        r_out_valid <= 1'b1;
        r_op_count  <= r_op_count + 16'd1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign op_count    = r_op_count;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_control_mul.sv
`timescale 1ns/1ps
module tb_control_mul;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic conj = 1'b0;
  logic in_ready, out_valid;
  logic a_sel, b_sel, pp1_ce, pp2_ce, sub, p_r_ce, p_i_ce;
  logic [15:0] op_count;
  logic [2:0]  dbg_state;

  // Behavioural datapath driven by the controls
  logic signed [15:0] a_r = '0, a_i = '0, b_r = '0, b_i = '0;
  logic signed [15:0] a_mux, b_mux;
  logic signed [31:0] w_mul;
  logic signed [31:0] pp1, pp2, p_r, p_i;
  logic [7:0] ctl;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [63:0] exp_q[$];
  int rise_q[$];
  logic ov_prev = 1'b0;

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  control_mul dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef CONTROL_MUL_CONJ_EN
    .conj(conj),
`endif
    .a_sel(a_sel), .b_sel(b_sel), .pp1_ce(pp1_ce), .pp2_ce(pp2_ce),
    .sub(sub), .p_r_ce(p_r_ce), .p_i_ce(p_i_ce),
    .op_count(op_count), .o_dbg_state(dbg_state)
  );

  assign a_mux = a_sel ? a_i : a_r;
  assign b_mux = b_sel ? b_i : b_r;
  assign w_mul = a_mux * b_mux;
  assign ctl   = {a_sel, b_sel, pp1_ce, pp2_ce, sub, p_r_ce, p_i_ce, in_ready};

  always @(posedge clk) begin
    if (pp1_ce) pp1 <= w_mul;
    if (pp2_ce) pp2 <= w_mul;
    if (p_r_ce) p_r <= sub ? (pp1 - pp2) : (pp1 + pp2);
    if (p_i_ce) p_i <= sub ? (pp1 - pp2) : (pp1 + pp2);
  end

  // Reference complex multiply in [7:-24] (operands are [3:-12])
  function automatic logic [63:0] cmul(input logic signed [15:0] ar, ai, br, bi,
                                       input logic cj);
    logic signed [31:0] rr, ii, ri, ir;
    rr = ar * br;
    ii = ai * bi;
    ri = ar * bi;
    ir = ai * br;
    if (cj) return {rr + ii, ir - ri};
    return {rr - ii, ri + ir};
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [63:0] e;
    #2;
    if (!rst) begin
      if (out_valid && !ov_prev) rise_q.push_back(cyc);
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got p_r=%h p_i=%h, expected no result", p_r, p_i);
        end else begin
          e = exp_q.pop_front();
          if ({p_r, p_i} !== e) begin
            errors++;
            $display("FAIL sb_result: got p_r=%h p_i=%h, want p_r=%h p_i=%h",
                     p_r, p_i, e[63:32], e[31:0]);
          end
        end
      end
    end
    ov_prev = out_valid;
  end

  // ---------------- driver tasks ----------------
  // Entered at a negedge; returns at the negedge after the input handshake.
  task automatic send_op(input logic [15:0] ar, ai, br, bi);
    a_r = ar; a_i = ai; b_r = br; b_i = bi;
    in_valid = 1'b1;
    exp_q.push_back(cmul(ar, ai, br, bi, conj));
    #1;
    for (int n = 0; n < 40 && in_ready !== 1'b1; n++) begin
      @(negedge clk); #1;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_timeout: in_ready=%b after 40 cycles, want 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (ctl !== 8'h00) begin errors++; $display("FAIL rst_ctl: got %b want 00000000", ctl); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (op_count !== 16'h0000) begin errors++; $display("FAIL rst_op_count: got %h want 0000", op_count); end
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    checks++; if ({ctl, dbg_state} !== {8'h00, 3'd0}) begin errors++; $display("FAIL post_rst_idle: got ctl=%b st=%0d want 0/0", ctl, dbg_state); end
  endtask

  task automatic test_single_op();
    logic [7:0] tbl [6];
    // {a_sel,b_sel,pp1,pp2,sub,p_r_ce,p_i_ce,in_ready}: IDLE..PI_WR
    tbl = '{8'h00, 8'h20, 8'hD0, 8'h6C, 8'h91, 8'h02};
    @(negedge clk);
    out_ready = 1'b1; conj = 1'b0;
    a_r = 16'h1000; a_i = 16'h2000; b_r = 16'h3000; b_i = 16'h4000;
    in_valid = 1'b1;
    exp_q.push_back(cmul(16'h1000, 16'h2000, 16'h3000, 16'h4000, 1'b0));
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 5) in_valid = 1'b0;
      #1;
      checks++;
      if (ctl !== tbl[k]) begin errors++; $display("FAIL single_ctl_c%0d: got %b want %b", k, ctl, tbl[k]); end
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early: out_valid=%b at cycle 5, want 0", out_valid); end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_latency: out_valid=%b at cycle 6, want 1", out_valid); end
    checks++; if (p_r !== 32'hFB000000) begin errors++; $display("FAIL single_p_r: got %h want FB000000", p_r); end
    checks++; if (p_i !== 32'h0A000000) begin errors++; $display("FAIL single_p_i: got %h want 0A000000", p_i); end
    checks++; if (op_count !== 16'd1) begin errors++; $display("FAIL single_count: got %0d want 1", op_count); end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_clear: out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    int s;
    @(negedge clk);
    out_ready = 1'b1;
    rise_q.delete();
    s = cyc;
    for (int i = 0; i < 3; i++)
      send_op(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
              16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #3;
    checks++;
    if (rise_q.size() != 3) begin
      errors++; $display("FAIL b2b_count: got %0d rises want 3", rise_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rise_q[i] != s + 6 + 4 * i) begin
          errors++; $display("FAIL b2b_rise%0d: got cycle %0d want %0d", i, rise_q[i] - s, 6 + 4 * i);
        end
      end
    end
    checks++; if (op_count !== 16'd4) begin errors++; $display("FAIL b2b_op_count: got %0d want 4", op_count); end
  endtask

  task automatic test_stall();
    logic [63:0] e1, e2;
    logic [15:0] v [4];
    @(negedge clk);
    out_ready = 1'b0;
    e1 = cmul(16'h0800, 16'hF000, 16'h1800, 16'h0400, 1'b0);
    send_op(16'h0800, 16'hF000, 16'h1800, 16'h0400);
    for (int i = 0; i < 4; i++) v[i] = 16'($urandom_range(0, 65535));
    a_r = v[0]; a_i = v[1]; b_r = v[2]; b_i = v[3];
    in_valid = 1'b1;
    e2 = cmul(v[0], v[1], v[2], v[3], 1'b0);
    exp_q.push_back(e2);
    @(negedge clk); @(negedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({ctl, dbg_state} !== {8'h00, 3'd3}) begin errors++; $display("FAIL stall_hold%0d: got ctl=%b st=%0d want 00000000/3", k, ctl, dbg_state); end
      checks++;
      if (p_r !== e1[63:32]) begin errors++; $display("FAIL stall_keep_p_r%0d: got %h want %h", k, p_r, e1[63:32]); end
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid%0d: got %b want 1", k, out_valid); end
      @(negedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    checks++; if (ctl !== 8'h6C) begin errors++; $display("FAIL stall_release: got %b want 01101100", ctl); end
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    checks++; if (p_r !== e2[63:32]) begin errors++; $display("FAIL stall_p_r_load: got %h want %h", p_r, e2[63:32]); end
    checks++; if ({dbg_state, out_valid} !== {3'd4, 1'b0}) begin errors++; $display("FAIL stall_after: got st=%0d ov=%b want 4/0", dbg_state, out_valid); end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    for (int n = 0; n < 10 && out_valid !== 1'b1; n++) begin @(negedge clk); #1; end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_done: out_valid=%b want 1", out_valid); end
    out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    logic [15:0] cnt_before;
    @(negedge clk);
    out_ready = 1'b1;
    cnt_before = op_count;
    a_r = 16'h0100; a_i = 16'h0200; b_r = 16'h0300; b_i = 16'h0400;
    in_valid = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    checks++; if ({dbg_state, in_ready} !== {3'd4, 1'b1}) begin errors++; $display("FAIL midrst_pre: got st=%0d rdy=%b want 4/1", dbg_state, in_ready); end
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    checks++; if (ctl !== 8'h00) begin errors++; $display("FAIL midrst_ctl: got %b want 00000000", ctl); end
    checks++; if ({out_valid, op_count} !== {1'b0, 16'h0000}) begin errors++; $display("FAIL midrst_regs: got ov=%b cnt=%h (was %h) want 0/0000", out_valid, op_count, cnt_before); end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      checks++;
      if ({ctl, dbg_state, out_valid} !== {8'h00, 3'd0, 1'b0}) begin
        errors++; $display("FAIL midrst_idle%0d: got ctl=%b st=%0d ov=%b want 0/0/0", k, ctl, dbg_state, out_valid);
      end
    end
    checks++; if (op_count !== 16'h0000) begin errors++; $display("FAIL midrst_count: got %h want 0000", op_count); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.r_op_count = 16'hFFFF;
    #1;
    release dut.r_op_count;
    #1;
    checks++; if (op_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: got %h want FFFF", op_count); end
    @(negedge clk);
    send_op(16'h1000, 16'h0000, 16'h1000, 16'h0000);
    in_valid = 1'b0;
    @(negedge clk); #1;
    checks++; if (op_count !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %h want 0000", op_count); end
    send_op(16'hF000, 16'h0800, 16'h0C00, 16'hE000);
    in_valid = 1'b0;
    @(negedge clk); #1;
    checks++; if (op_count !== 16'h0001) begin errors++; $display("FAIL wrap_one: got %h want 0001", op_count); end
    @(negedge clk);
  endtask

`ifdef CONTROL_MUL_CONJ_EN
  task automatic test_conj();
    @(negedge clk);
    out_ready = 1'b1;
    conj = 1'b1;
    send_op(16'h1000, 16'h2000, 16'h3000, 16'h4000);
    in_valid = 1'b0;
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL conj_valid: got %b want 1", out_valid); end
    checks++; if (p_r !== 32'h0B000000) begin errors++; $display("FAIL conj_p_r: got %h want 0B000000", p_r); end
    checks++; if (p_i !== 32'h02000000) begin errors++; $display("FAIL conj_p_i: got %h want 02000000", p_i); end
    conj = 1'b0;
    @(negedge clk);
  endtask
`endif

  // ---------------- main sequence + report ----------------
  initial begin
    test_reset();
    test_single_op();
    test_back_to_back();
    test_stall();
    test_reset_mid_op();
    test_wrap();
`ifdef CONTROL_MUL_CONJ_EN
    test_conj();
`endif
    repeat (4) @(negedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover: %0d results never delivered, want 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by 200000 ns");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/control_mul.md
CONTROL_MUL -- requirements
Module: control_mul

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port in_valid  input  1  operand pair a,b present on the datapath inputs and held stable until accepted.
REQ-004 SHALL have port in_ready  output  1  operand acceptance; in_valid AND in_ready completes the input transfer.
REQ-005 SHALL have port out_valid  output  1  p_r/p_i registers hold a complete result.
REQ-006 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-007 SHALL have ports a_sel, b_sel, pp1_ce, pp2_ce, sub, p_r_ce, p_i_ce  output  1 each  datapath controls (sel 0 = real part, 1 = imaginary part; sub 1 = pp1-pp2, 0 = pp1+pp2).
REQ-008 SHALL have port op_count  output  16  count of completed results.

Function
REQ-009 SHALL use states IDLE, PP_RR, PP_II, PR_RI, PP_IR, PI_WR.
REQ-010 Datapath controls SHALL be a combinational decode of state and stall; every control not listed for a state SHALL be 0.
REQ-011 IDLE: no enables; in_valid=1 -> PP_RR.
REQ-012 PP_RR: a_sel=0, b_sel=0, pp1_ce=1 (ar*br) -> PP_II.
REQ-013 PP_II: a_sel=1, b_sel=1, pp2_ce=1 (ai*bi) -> PR_RI.
REQ-014 PR_RI: sub=1, p_r_ce=1, a_sel=0, b_sel=1, pp1_ce=1 (ar*bi) -> PP_IR.
REQ-015 Stall: in PR_RI with out_valid=1 and out_ready=0, all enables SHALL be 0 and the state SHALL hold; out_valid=1 with out_ready=1 in the same cycle SHALL NOT stall.
REQ-016 PP_IR: a_sel=1, b_sel=0, pp2_ce=1 (ai*br), in_ready=1 -> PI_WR; in_ready SHALL be 1 only in PP_IR.
REQ-017 PI_WR: sub=0, p_i_ce=1; if in_valid=1, also issue the PP_RR controls (a_sel=0, b_sel=0, pp1_ce=1) -> PP_II; else -> IDLE.
REQ-018 Latency: in_valid sampled in IDLE at cycle 0 -> out_valid=1 at cycle 6; back-to-back throughput SHALL be one result per 4 cycles.
REQ-019 out_valid SHALL set on the clock edge that ends PI_WR and clear on the edge where out_valid AND out_ready, unless the same edge sets it.
REQ-020 op_count SHALL increment by 1 on the edge ending PI_WR and wrap from 16'hFFFF to 16'h0000.
REQ-021 The datapath product format SHALL be [7:-24]; the controller performs no arithmetic and does not alter widths.

Reset
REQ-022 While rst=1: state=IDLE, out_valid=0, op_count=0; all datapath controls and in_ready SHALL be 0 immediately, without waiting for a clock edge.
REQ-023 Reset mid-operation SHALL abandon the operation: no p_r_ce/p_i_ce pulse and no op_count increment for it.

Configuration
REQ-024 With CONTROL_MUL_CONJ_EN defined, the module SHALL have an extra input conj (1 bit), sampled into an internal register on every cycle that issues the PP_RR controls.
REQ-025 With CONTROL_MUL_CONJ_EN defined and the latched conj=1, the result SHALL be a*conj(b): PR_RI uses sub=0 with a_sel=1, b_sel=0 for pp1; PP_IR uses a_sel=0, b_sel=1 for pp2; PI_WR uses sub=1; all other behaviour is unchanged.
REQ-026 Without CONTROL_MUL_CONJ_EN, the conj port and register SHALL NOT exist, and the behaviour SHALL be the plain product a*b.

Verification
REQ-027 Single op: a=1+2i, b=3+4i, in_valid pulse held until in_ready -> out_valid at cycle 6, p_r=32'hFB000000, p_i=32'h0A000000, op_count=1.
REQ-028 Back-to-back: 3 ops with in_valid held and out_ready=1 -> out_valid rises at cycles 6, 10, 14, and each result is correct.
REQ-029 Stall: out_ready=0 while a second op is in flight -> the second op holds in PR_RI with no enables; release out_ready for 1 cycle -> p_r loads on the next edge.
REQ-030 Reset: assert rst during PP_IR -> enables and in_ready are 0 at once; after release the state is IDLE, out_valid=0, op_count=0.
REQ-031 Wrap: preload 65535 completions -> the next completion gives op_count=0.
REQ-032 CONJ_EN build: a=1+2i, b=3+4i, conj=1 -> p_r=32'h0B000000, p_i=32'h02000000.
